countdown_timer: RTL and testbench

//   BCD countdown timer for the multifunction clock: counts MM:SS.cc down to 00:00.00 at 1 tick per clk100hz.

---
 rtl/countdown_timer_if.sv | 62 ++++++
 rtl/countdown_timer.sv | 207 ++++++++++++++++++++
 tb/tb_countdown_timer.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/countdown_timer_if.sv
// Control, preset and display/status signals between the key block, the
// countdown timer and the display mux / buzzer driver.
interface countdown_timer_if;

    // Control pulses and preset digits (BCD)
    logic       load;
    logic       start_stop;
    logic [3:0] preset_min_t;
    logic [3:0] preset_min_u;
    logic [3:0] preset_sec_t;
    logic [3:0] preset_sec_u;

    // Current count (BCD) and status
    logic [3:0] min_t;
    logic [3:0] min_u;
    logic [3:0] sec_t;
    logic [3:0] sec_u;
    logic [3:0] cs_t;
    logic [3:0] cs_u;
    logic       running;
    logic       done;
    logic       alarm;

    // Key block / controller side
    modport master (
        output load,
        output start_stop,
        output preset_min_t,
        output preset_min_u,
        output preset_sec_t,
        output preset_sec_u,
        input  min_t,
        input  min_u,
        input  sec_t,
        input  sec_u,
        input  cs_t,
        input  cs_u,
        input  running,
        input  done,
        input  alarm
    );

    // Timer side
    modport slave (
        input  load,
        input  start_stop,
        input  preset_min_t,
        input  preset_min_u,
        input  preset_sec_t,
        input  preset_sec_u,
        output min_t,
        output min_u,
        output sec_t,
        output sec_u,
        output cs_t,
        output cs_u,
        output running,
        output done,
        output alarm
    );

endinterface

// File: rtl/countdown_timer.sv
// BCD MM:SS.cc countdown timer, one hundredth per clk100hz edge.
// Borrow-chained down-counter with IDLE/RUN/PAUSE/ALARM control; the alarm
// output is held for ALARM_TICKS cycles after the count reaches zero.
module countdown_timer #(
    parameter int unsigned ALARM_TICKS = 300
) (
    input  logic             clk100hz,
    input  logic             rst,
    countdown_timer_if.slave io_bus
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StPause,
        StAlarm
    } state_e;

    // Last value of the alarm timer before returning to IDLE
    localparam logic [9:0] AlarmLast = 10'(ALARM_TICKS - 1);

    // Saturate a preset digit to its legal maximum
    function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] lim);
        return (d > lim) ? lim : d;
    endfunction

    // One mod-N down-count step: 0 wraps to the stage maximum
    function automatic logic [3:0] dec_digit(input logic [3:0] d, input logic [3:0] wrap);
        return (d == 4'd0) ? wrap : d - 4'd1;
    endfunction

    state_e     r_state;
    state_e     w_state_d;

    logic [3:0] r_min_t, r_min_u, r_sec_t, r_sec_u, r_cs_t, r_cs_u;
    logic [3:0] w_min_t_d, w_min_u_d, w_sec_t_d, w_sec_u_d, w_cs_t_d, w_cs_u_d;

    logic [9:0] r_alarm_cnt;
    logic [9:0] w_alarm_cnt_d;

    logic       r_running, r_done, r_alarm;
    logic       w_running_d, w_done_d, w_alarm_d;

    // Borrow into each stage: every lower stage is currently zero
    logic       w_brw_cs_t, w_brw_sec_u, w_brw_sec_t, w_brw_min_u, w_brw_min_t;
    logic       w_count_zero;
    logic       w_count_one;
    logic       w_alarm_last;
    logic       w_tick;
    logic       w_load;
    logic       w_start_stop;

    assign w_load       = io_bus.load;
    assign w_start_stop = io_bus.start_stop;

    assign w_brw_cs_t   = (r_cs_u == 4'd0);
    assign w_brw_sec_u  = w_brw_cs_t  && (r_cs_t  == 4'd0);
    assign w_brw_sec_t  = w_brw_sec_u && (r_sec_u == 4'd0);
    assign w_brw_min_u  = w_brw_sec_t && (r_sec_t == 4'd0);
    assign w_brw_min_t  = w_brw_min_u && (r_min_u == 4'd0);
    assign w_count_zero = w_brw_min_t && (r_min_t == 4'd0);

    // 00:00.01 is the last count before the terminal edge
    assign w_count_one  = (r_min_t == 4'd0) && (r_min_u == 4'd0) && (r_sec_t == 4'd0) &&
                          (r_sec_u == 4'd0) && (r_cs_t == 4'd0) && (r_cs_u == 4'd1);

    assign w_alarm_last = (r_alarm_cnt == AlarmLast);

    // Control pulses take priority over the count tick; never tick past zero
    assign w_tick = (r_state == StRun) && !w_load && !w_start_stop && !w_count_zero;

    // State register
    always_ff @(posedge clk100hz or negedge rst) begin
        if (!rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next-state decode: load > start_stop > tick
    always_comb begin
        w_state_d = r_state;
        if (w_load) begin
            w_state_d = StIdle;
        end else if (w_start_stop) begin
            unique case (r_state)
                StIdle:  w_state_d = w_count_zero ? StIdle : StRun;
                StRun:   w_state_d = StPause;
                StPause: w_state_d = StRun;
                StAlarm: w_state_d = StIdle;
                default: w_state_d = StIdle;
            endcase
        end else begin
            unique case (r_state)
                StIdle:  w_state_d = StIdle;
                StRun:   w_state_d = w_count_one ? StAlarm : StRun;
                StPause: w_state_d = StPause;
                StAlarm: w_state_d = w_alarm_last ? StIdle : StAlarm;
                default: w_state_d = StIdle;
            endcase
        end
    end

    // Next values of the registered status outputs, derived from the next state
    always_comb begin
        w_running_d = (w_state_d == StRun);
        w_alarm_d   = (w_state_d == StAlarm);
        w_done_d    = (r_state == StRun) && (w_state_d == StAlarm);
    end

    // Status output registers
    always_ff @(posedge clk100hz or negedge rst) begin
        if (!rst) begin
            r_running <= 1'b0;
            r_done    <= 1'b0;
            r_alarm   <= 1'b0;
        end else begin
            r_running <= w_running_d;
            r_done    <= w_done_d;
            r_alarm   <= w_alarm_d;
        end
    end

    // Alarm timer: counts edges spent in ALARM, zero everywhere else
    always_comb begin
        w_alarm_cnt_d = 10'd0;
        if ((r_state == StAlarm) && (w_state_d == StAlarm)) begin
            w_alarm_cnt_d = r_alarm_cnt + 10'd1;
        end
    end

    // Alarm timer register
    always_ff @(posedge clk100hz or negedge rst) begin
        if (!rst) begin
            r_alarm_cnt <= 10'd0;
        end else begin
            r_alarm_cnt <= w_alarm_cnt_d;
        end
    end

    // Digit datapath: clamped preset on load, borrow-chain decrement on tick
    always_comb begin
        w_min_t_d = r_min_t;
        w_min_u_d = r_min_u;
        w_sec_t_d = r_sec_t;
        w_sec_u_d = r_sec_u;
        w_cs_t_d  = r_cs_t;
        w_cs_u_d  = r_cs_u;
        if (w_load) begin
            w_min_t_d = clamp_digit(io_bus.preset_min_t, 4'd5);
            w_min_u_d = clamp_digit(io_bus.preset_min_u, 4'd9);
            w_sec_t_d = clamp_digit(io_bus.preset_sec_t, 4'd5);
            w_sec_u_d = clamp_digit(io_bus.preset_sec_u, 4'd9);
            w_cs_t_d  = 4'd0;
            w_cs_u_d  = 4'd0;
        end else if (w_tick) begin
            w_cs_u_d = dec_digit(r_cs_u, 4'd9);
            if (w_brw_cs_t) begin
                w_cs_t_d = dec_digit(r_cs_t, 4'd9);
            end
            if (w_brw_sec_u) begin
                w_sec_u_d = dec_digit(r_sec_u, 4'd9);
            end
            if (w_brw_sec_t) begin
                w_sec_t_d = dec_digit(r_sec_t, 4'd5);
            end
            if (w_brw_min_u) begin
                w_min_u_d = dec_digit(r_min_u, 4'd9);
            end
            // w_tick excludes a zero count, so min_t is nonzero whenever it borrows
            if (w_brw_min_t) begin
                w_min_t_d = r_min_t - 4'd1;
            end
        end
    end

    // Digit registers
    always_ff @(posedge clk100hz or negedge rst) begin
        if (!rst) begin
            r_min_t <= 4'd0;
            r_min_u <= 4'd0;
            r_sec_t <= 4'd0;
            r_sec_u <= 4'd0;
            r_cs_t  <= 4'd0;
            r_cs_u  <= 4'd0;
        end else begin
            r_min_t <= w_min_t_d;
            r_min_u <= w_min_u_d;
            r_sec_t <= w_sec_t_d;
            r_sec_u <= w_sec_u_d;
            r_cs_t  <= w_cs_t_d;
            r_cs_u  <= w_cs_u_d;
        end
    end

    assign io_bus.min_t   = r_min_t;
    assign io_bus.min_u   = r_min_u;
    assign io_bus.sec_t   = r_sec_t;
    assign io_bus.sec_u   = r_sec_u;
    assign io_bus.cs_t    = r_cs_t;
    assign io_bus.cs_u    = r_cs_u;
    assign io_bus.running = r_running;
    assign io_bus.done    = r_done;
    assign io_bus.alarm   = r_alarm;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: a directed vector table for single-edge behaviour
// plus hand-written sequences for terminal count, alarm, pause and async reset.
module tb_countdown_timer;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    countdown_timer_if bus ();

    countdown_timer #(
        .ALARM_TICKS(300)
    ) dut (
        .clk100hz(clk),
        .rst     (rst_n),
        .io_bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ld;
        logic        ss;
        logic [15:0] preset;   // {min_t, min_u, sec_t, sec_u}
        logic [23:0] exp_dig;  // {min_t, min_u, sec_t, sec_u, cs_t, cs_u}
        logic        exp_run;
        logic        exp_done;
        logic        exp_alm;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic ld, input logic ss, input logic [15:0] p,
                                input logic [23:0] d, input logic r, input logic dn,
                                input logic a);
        vec_t v;
        v.ld = ld; v.ss = ss; v.preset = p; v.exp_dig = d;
        v.exp_run = r; v.exp_done = dn; v.exp_alm = a;
        return v;
    endfunction

    // Reference: hundredths remaining -> BCD display digits
    function automatic logic [23:0] to_bcd(input int h);
        int m, s, c;
        m = h / 6000;
        s = (h / 100) % 60;
        c = h % 100;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
    endfunction

    function automatic logic [26:0] observe();
        return {bus.min_t, bus.min_u, bus.sec_t, bus.sec_u, bus.cs_t, bus.cs_u,
                bus.running, bus.done, bus.alarm};
    endfunction

    task automatic chk(input string name, input logic [26:0] exp);
        logic [26:0] act;
        act = observe();
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got dig=%h r/d/a=%b want dig=%h r/d/a=%b",
                     name, act[26:3], act[2:0], exp[26:3], exp[2:0]);
        end
    endtask

    // One clock edge with the given control pulses; outputs sampled 1 unit later
    task automatic step(input logic ld, input logic ss, input logic [15:0] p);
        bus.load         = ld;
        bus.start_stop   = ss;
        bus.preset_min_t = p[15:12];
        bus.preset_min_u = p[11:8];
        bus.preset_sec_t = p[7:4];
        bus.preset_sec_u = p[3:0];
        @(posedge clk);
        #1;
        bus.load       = 1'b0;
        bus.start_stop = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        bus.load = 1'b0;
        bus.start_stop = 1'b0;
        bus.preset_min_t = 4'd0;
        bus.preset_min_u = 4'd0;
        bus.preset_sec_t = 4'd0;
        bus.preset_sec_u = 4'd0;

        // Single-edge vectors; presets change without load on some rows
        vecs.push_back(mk(1, 0, 16'h7C8F, 24'h595900, 0, 0, 0)); // clamp to 59:59.00
        vecs.push_back(mk(0, 0, 16'h0000, 24'h595900, 0, 0, 0)); // preset ignored w/o load
        vecs.push_back(mk(1, 0, 16'h0000, 24'h000000, 0, 0, 0));
        vecs.push_back(mk(0, 1, 16'h0000, 24'h000000, 0, 0, 0)); // start at zero: stay idle
        vecs.push_back(mk(1, 0, 16'h0100, 24'h010000, 0, 0, 0));
        vecs.push_back(mk(0, 1, 16'h0100, 24'h010000, 1, 0, 0)); // start, no decrement
        vecs.push_back(mk(0, 0, 16'h0100, 24'h005999, 1, 0, 0));
        vecs.push_back(mk(0, 0, 16'h0100, 24'h005998, 1, 0, 0));
        vecs.push_back(mk(1, 1, 16'h3210, 24'h321000, 0, 0, 0)); // load beats start_stop
        vecs.push_back(mk(0, 1, 16'h3210, 24'h321000, 1, 0, 0));
        vecs.push_back(mk(0, 0, 16'h3210, 24'h320999, 1, 0, 0));
        vecs.push_back(mk(0, 1, 16'h3210, 24'h320999, 0, 0, 0)); // pause
        vecs.push_back(mk(0, 0, 16'h9999, 24'h320999, 0, 0, 0));
        vecs.push_back(mk(0, 1, 16'h9999, 24'h320999, 1, 0, 0)); // resume
        vecs.push_back(mk(0, 0, 16'h9999, 24'h320998, 1, 0, 0));
        vecs.push_back(mk(1, 0, 16'h5959, 24'h595900, 0, 0, 0));
        vecs.push_back(mk(0, 1, 16'h5959, 24'h595900, 1, 0, 0));
        vecs.push_back(mk(0, 0, 16'h5959, 24'h595899, 1, 0, 0));
        vecs.push_back(mk(0, 1, 16'h5959, 24'h595899, 0, 0, 0)); // pause
        vecs.push_back(mk(1, 0, 16'h0A60, 24'h095000, 0, 0, 0)); // load in pause, clamp
        vecs.push_back(mk(1, 0, 16'h0000, 24'h000000, 0, 0, 0));

        // Async reset with no clock edge yet
        rst_n = 1'b0;
        #2;
        chk("reset", 27'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].ld, vecs[i].ss, vecs[i].preset);
            chk($sformatf("vec%0d", i),
                {vecs[i].exp_dig, vecs[i].exp_run, vecs[i].exp_done, vecs[i].exp_alm});
        end

        // 00:02 run to zero, done on edge 200, alarm for 300 cycles
        step(1, 0, 16'h0002);
        chk("a_load", {to_bcd(200), 3'b000});
        step(0, 1, 16'h0002);
        chk("a_start", {to_bcd(200), 3'b100});
        for (int i = 1; i <= 200; i++) begin
            step(0, 0, 16'h0002);
            chk($sformatf("a_run%0d", i),
                {to_bcd(200 - i), (i < 200), (i == 200), (i == 200)});
        end
        for (int j = 1; j <= 300; j++) begin
            step(0, 0, 16'h0002);
            chk($sformatf("a_alarm%0d", j), {to_bcd(0), 1'b0, 1'b0, (j < 300)});
        end
        step(0, 1, 16'h0002);
        chk("a_idle_start", {to_bcd(0), 3'b000});

        // Pause from 10:00 after 50 ticks, hold 100 cycles, resume
        step(1, 0, 16'h1000);
        step(0, 1, 16'h1000);
        for (int i = 1; i <= 50; i++) begin
            step(0, 0, 16'h1000);
            chk($sformatf("b_run%0d", i), {to_bcd(60000 - i), 3'b100});
        end
        step(0, 1, 16'h1000);
        chk("b_pause", {24'h095950, 3'b000});
        for (int i = 1; i <= 100; i++) begin
            step(0, 0, 16'h1000);
            chk($sformatf("b_hold%0d", i), {24'h095950, 3'b000});
        end
        step(0, 1, 16'h1000);
        chk("b_resume", {24'h095950, 3'b100});
        step(0, 0, 16'h1000);
        chk("b_resume_tick", {24'h095949, 3'b100});

        // Alarm acknowledged early by start_stop
        step(1, 0, 16'h0001);
        step(0, 1, 16'h0001);
        for (int i = 1; i <= 100; i++) step(0, 0, 16'h0001);
        chk("c_terminal", {to_bcd(0), 3'b011});
        for (int i = 1; i <= 5; i++) step(0, 0, 16'h0001);
        chk("c_alarm_hold", {to_bcd(0), 3'b001});
        step(0, 1, 16'h0001);
        chk("c_ack", {to_bcd(0), 3'b000});
        step(0, 0, 16'h0001);
        chk("c_ack_idle", {to_bcd(0), 3'b000});

        // Load during alarm aborts it
        step(1, 0, 16'h0001);
        step(0, 1, 16'h0001);
        for (int i = 1; i <= 103; i++) step(0, 0, 16'h0001);
        chk("d_in_alarm", {to_bcd(0), 3'b001});
        step(1, 0, 16'h0100);
        chk("d_load_alarm", {24'h010000, 3'b000});

        // Async reset mid-run at 03:21.45
        step(1, 0, 16'h0322);
        step(0, 1, 16'h0322);
        for (int i = 1; i <= 55; i++) step(0, 0, 16'h0322);
        chk("e_at_032145", {24'h032145, 3'b100});
        #2;
        rst_n = 1'b0;
        #1;
        chk("e_async_rst", 27'd0);
        step(0, 1, 16'h0322);
        chk("e_rst_held", 27'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 16'h0322);
        chk("e_after_rst", 27'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
